// File: rtl/thermocouple_scanner.sv
// Round-robin poller for NUM_CH MAX31855-style converters behind one SPI master.
// Ports: clk, rst_n, spi_not_busy, spi_rx_data in; spi_ena, ch_sel, per-channel
// tc/junction/fault/valid registers, scan_done strobe and fault_any out.
module thermocouple_scanner #(
  parameter int CLK_FREQ    = 4000,
  parameter int NUM_CH      = 4,
  parameter int CH_BITS     = 2,
  parameter int STARTUP_SEC = 3,
  parameter int PERIOD_SEC  = 1,
  parameter int TIMEOUT_CYC = 64,
  parameter int CBITS       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_not_busy,
  input  logic [31:0]           spi_rx_data,
  output logic                  spi_ena,
  output logic [CH_BITS-1:0]    ch_sel,
  output logic [14*NUM_CH-1:0]  tc_temp_data,
  output logic [12*NUM_CH-1:0]  junction_temp_data,
  output logic [4*NUM_CH-1:0]   fault_bits,
  output logic [NUM_CH-1:0]     data_valid,
  output logic                  scan_done,
  output logic                  fault_any
);

  localparam logic [CBITS-1:0] ST_LAST =
    CBITS'(CLK_FREQ*STARTUP_SEC - 1);
  localparam logic [CBITS-1:0] PER_LAST =
    CBITS'(CLK_FREQ*PERIOD_SEC - 1);
  localparam logic [CBITS-1:0] TMO =
    CBITS'(TIMEOUT_CYC);
  localparam logic [CH_BITS-1:0] LAST_CH =
    CH_BITS'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_STARTUP = 3'd0,
    S_REQ     = 3'd1,
    S_CAPT    = 3'd2,
    S_ADV     = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t               r_state;
  logic [CBITS-1:0]     r_cnt;
  logic [CBITS-1:0]     r_tmo;
  logic [CH_BITS-1:0]   r_ch;
  logic [14*NUM_CH-1:0] r_tc;
  logic [12*NUM_CH-1:0] r_jn;
  logic [4*NUM_CH-1:0]  r_fault;
  logic [NUM_CH-1:0]    r_dv;

  state_t               w_nxt;
  logic [CBITS-1:0]     w_cnt;
  logic [CBITS-1:0]     w_tmo;
  logic [CH_BITS-1:0]   w_ch;
  logic                 w_ena;
  logic                 w_done;
  logic                 w_capt;
  logic                 w_tout;
  logic                 w_hit;

  assign w_hit = (r_tmo == TMO);

  always_comb begin
    w_nxt  = r_state;
    w_cnt  = r_cnt;
    w_tmo  = r_tmo;
    w_ch   = r_ch;
    w_ena  = 1'b0;
    w_done = 1'b0;
    w_capt = 1'b0;
    w_tout = 1'b0;
    case (r_state)
      S_STARTUP: begin
        if (r_cnt == ST_LAST) begin
          w_cnt = '0;
          w_ch  = '0;
          w_nxt = S_REQ;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_REQ: begin
        if (w_hit) begin
          w_tout = 1'b1;
          w_tmo  = '0;
          w_nxt  = S_ADV;
        end else if (spi_not_busy) begin
          w_ena = 1'b1;
          w_tmo = r_tmo + 1'b1;
        end else begin
          // master went busy: our frame is in flight
          w_tmo = '0;
          w_nxt = S_CAPT;
        end
      end
      S_CAPT: begin
        if (w_hit) begin
          w_tout = 1'b1;
          w_tmo  = '0;
          w_nxt  = S_ADV;
        end else if (spi_not_busy) begin
          w_capt = 1'b1;
          w_tmo  = '0;
          w_nxt  = S_ADV;
        end else begin
          w_tmo = r_tmo + 1'b1;
        end
      end
      S_ADV: begin
        w_tmo = '0;
        if (r_ch == LAST_CH) begin
          w_ch   = '0;
          w_done = 1'b1;
          w_cnt  = '0;
          w_nxt  = S_HOLD;
        end else begin
          w_ch  = r_ch + 1'b1;
          w_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        if (r_cnt == PER_LAST) begin
          w_cnt = '0;
          w_nxt = S_REQ;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_tmo = '0;
        w_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_STARTUP;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_ch    <= '0;
      r_tc    <= '0;
      r_jn    <= '0;
      r_fault <= '0;
      r_dv    <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_tmo   <= w_tmo;
      r_ch    <= w_ch;
      if (w_capt) begin
        r_fault[4*r_ch +: 4] <=
          {spi_rx_data[16], spi_rx_data[2:0]};
        r_dv[r_ch] <= ~spi_rx_data[16];
        // a faulted frame carries no usable temperatures
        if (!spi_rx_data[16]) begin
          r_tc[14*r_ch +: 14] <= spi_rx_data[31:18];
          r_jn[12*r_ch +: 12] <= spi_rx_data[15:4];
        end
      end else if (w_tout) begin
        r_fault[4*r_ch +: 4] <= 4'hF;
        r_dv[r_ch]           <= 1'b0;
      end
    end
  end

  assign spi_ena            = w_ena;
  assign scan_done          = w_done;
  assign ch_sel             = r_ch;
  assign tc_temp_data       = r_tc;
  assign junction_temp_data = r_jn;
  assign fault_bits         = r_fault;
  assign data_valid         = r_dv;
  assign fault_any          = |r_fault;

endmodule

// File: tb/tb_thermocouple_scanner.sv
// Bench for thermocouple_scanner: SPI converter model, expected-result
// queue popped by a monitor on every scan_done strobe.
module tb_thermocouple_scanner;

  logic        clk;
  logic        rst_n;
  logic        spi_not_busy;
  logic [31:0] spi_rx_data;
  logic        spi_ena;
  logic [0:0]  ch_sel;
  logic [27:0] tc_temp_data;
  logic [23:0] junction_temp_data;
  logic [7:0]  fault_bits;
  logic [1:0]  data_valid;
  logic        scan_done;
  logic        fault_any;

  thermocouple_scanner #(
    .CLK_FREQ(8), .NUM_CH(2), .CH_BITS(1),
    .STARTUP_SEC(1), .PERIOD_SEC(1),
    .TIMEOUT_CYC(5), .CBITS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_not_busy(spi_not_busy),
    .spi_rx_data(spi_rx_data),
    .spi_ena(spi_ena),
    .ch_sel(ch_sel),
    .tc_temp_data(tc_temp_data),
    .junction_temp_data(junction_temp_data),
    .fault_bits(fault_bits),
    .data_valid(data_valid),
    .scan_done(scan_done),
    .fault_any(fault_any)
  );

  typedef struct {
    logic [27:0] tc;
    logic [23:0] jn;
    logic [7:0]  flt;
    logic [1:0]  dv;
    logic        fany;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          mode   = 0;
  logic [31:0] frame[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Converter model. mode 0: busy drops 2 cycles after spi_ena and
  // returns 3 cycles later. mode 1: never goes busy. mode 2: goes busy
  // and never returns.
  initial begin
    spi_not_busy = 1'b1;
    spi_rx_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (mode != 2) spi_not_busy = 1'b1;
      if (spi_ena && mode != 1) begin
        repeat (2) @(posedge clk);
        #1;
        spi_rx_data  = frame[ch_sel];
        spi_not_busy = 1'b0;
        if (mode == 0) begin
          repeat (3) @(posedge clk);
          #1;
          spi_not_busy = 1'b1;
        end
      end
    end
  end

  // Monitor: each scan_done pops one expected register snapshot.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && scan_done) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chk("sb_tc", 64'(tc_temp_data), 64'(e.tc));
          chk("sb_jn", 64'(junction_temp_data), 64'(e.jn));
          chk("sb_fault", 64'(fault_bits), 64'(e.flt));
          chk("sb_valid", 64'(data_valid), 64'(e.dv));
          chk("sb_fany", 64'(fault_any), 64'(e.fany));
        end
      end
    end
  end

  task automatic push(input logic [27:0] tc,
                      input logic [23:0] jn,
                      input logic [7:0]  flt,
                      input logic [1:0]  dv,
                      input logic        fany);
    exp_t e;
    e.tc = tc; e.jn = jn; e.flt = flt;
    e.dv = dv; e.fany = fany;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    logic got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (scan_done) begin
        got = 1'b1;
        break;
      end
    end
    chk(nm, 64'(got), 1);
  endtask

  task automatic wait_ena(input string nm);
    logic got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (spi_ena) begin
        got = 1'b1;
        break;
      end
    end
    chk(nm, 64'(got), 1);
  endtask

  // Counts cycles of spi_ena low before the first request.
  task automatic quiet_len(input string nm, input int want);
    int cnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (spi_ena) break;
      cnt++;
    end
    chk(nm, 64'(cnt), 64'(want));
    chk({nm, "_ch"}, 64'(ch_sel), 0);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_ena"}, 64'(spi_ena), 0);
    chk({p, "_ch"}, 64'(ch_sel), 0);
    chk({p, "_tc"}, 64'(tc_temp_data), 0);
    chk({p, "_jn"}, 64'(junction_temp_data), 0);
    chk({p, "_fault"}, 64'(fault_bits), 0);
    chk({p, "_valid"}, 64'(data_valid), 0);
    chk({p, "_done"}, 64'(scan_done), 0);
    chk({p, "_fany"}, 64'(fault_any), 0);
  endtask

  initial begin
    int cnt;
    logic got;
    frame[0] = 32'h0C80_1230;
    frame[1] = 32'h0640_0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");

    // startup: release just after an edge so cnt=0 spans a full cycle
    @(posedge clk); #1;
    rst_n = 1'b1;
    push({14'h0190, 14'h0320}, {12'h000, 12'h123},
         8'h00, 2'b11, 1'b0);
    quiet_len("startup_len", 8);

    // normal scan, then hold length
    wait_done("scan1_done");
    frame[1] = 32'h0001_0001;
    push({14'h0190, 14'h0320}, {12'h000, 12'h123},
         8'h90, 2'b01, 1'b1);
    quiet_len("hold_len", 8);

    // fault frame on ch1
    wait_done("scan2_done");
    mode = 1;
    push({14'h0190, 14'h0320}, {12'h000, 12'h123},
         8'hFF, 2'b00, 1'b1);

    // timeout in REQ: busy never drops
    wait_ena("tmo_ena");
    chk("tmo_ch0", 64'(ch_sel), 0);
    cnt = 1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!spi_ena) break;
      cnt++;
    end
    chk("tmo_req_cycles", 64'(cnt), 5);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ch_sel == 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("tmo_ch_adv", 64'(got), 1);
    chk("tmo_fault0", 64'(fault_bits[3:0]), 64'hF);
    wait_done("scan3_done");

    // stuck busy in CAPT: scans must keep completing
    mode = 2;
    push({14'h0190, 14'h0320}, {12'h000, 12'h123},
         8'hFF, 2'b00, 1'b1);
    push({14'h0190, 14'h0320}, {12'h000, 12'h123},
         8'hFF, 2'b00, 1'b1);
    wait_done("scan4_done");
    wait_done("scan5_done");

    // async reset in the middle of CAPT
    mode = 0;
    wait_ena("rst_ena");
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!spi_not_busy) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_busy_seen", 64'(got), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet_len("restart_len", 8);

    chk("sb_left", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thermocouple_scanner.md
Name: thermocouple_scanner

Overview:
- Multi-channel successor to the single-channel thermocouple reader.
- After a power-up settle delay, polls NUM_CH MAX31855-style converters in round-robin through a shared SPI master: one 32-bit frame per channel, then an inter-scan hold.
- Unpacks each frame into per-channel temperature, junction and fault registers.
- Adds per-channel fault gating, a bounded SPI timeout so the scan can never stall, and a scan-complete strobe.

Parameters:
- CLK_FREQ, 4000: clock cycles per second.
- NUM_CH, 4: number of converters, 1..16.
- CH_BITS, 2: channel index width, >= clog2(NUM_CH), minimum 1.
- STARTUP_SEC, 3: power-up settle time in seconds.
- PERIOD_SEC, 1: hold between scans in seconds.
- TIMEOUT_CYC, 64: maximum cycles per SPI phase before abort.
- CBITS, 16: counter width; 2^CBITS > CLK_FREQ*max(STARTUP_SEC,PERIOD_SEC) and > TIMEOUT_CYC.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- spi_not_busy  in  1  SPI master idle flag.
- spi_rx_data  in  32  last received SPI frame.
- spi_ena  out  1  SPI transaction request.
- ch_sel  out  CH_BITS  chip-select index of the channel being polled.
- tc_temp_data  out  14*NUM_CH  channel k at bits [14k+13:14k].
- junction_temp_data  out  12*NUM_CH  channel k at bits [12k+11:12k].
- fault_bits  out  4*NUM_CH  channel k at bits [4k+3:4k].
- data_valid  out  NUM_CH  channel k holds a fault-free sample.
- scan_done  out  1  one-cycle pulse when a full scan completes.
- fault_any  out  1  OR of all channels' fault_bits.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state=STARTUP, cnt=0, tmo=0, ch=0. Reset mid-transaction abandons the frame; no register is written.
- Derived constants: STARTUP_CYC = CLK_FREQ*STARTUP_SEC; PERIOD_CYC = CLK_FREQ*PERIOD_SEC.
- STARTUP:
  - cnt increments each cycle.
  - When cnt == STARTUP_CYC-1: cnt=0, ch=0, go to REQ.
- REQ:
  - spi_not_busy=1: spi_ena=1, tmo++.
  - spi_not_busy=0: the transaction has started. spi_ena=0, tmo=0, go to CAPT.
- CAPT:
  - spi_ena=0. Wait for spi_not_busy=1, incrementing tmo.
  - On spi_not_busy=1, capture channel ch in that cycle:
    - tc = spi_rx_data[31:18]
    - jn = spi_rx_data[15:4]
    - fault nibble = {spi_rx_data[16], spi_rx_data[2:0]}
  - If spi_rx_data[16]=1: fault_bits updated, tc and jn retain their previous values, data_valid[ch]=0.
  - If spi_rx_data[16]=0: tc, jn and fault_bits all updated, data_valid[ch]=1.
  - Then go to ADV.
- Timeout:
  - Applies in REQ or CAPT when tmo reaches TIMEOUT_CYC.
  - fault_bits[ch]=4'b1111, data_valid[ch]=0, spi_ena=0, tmo=0, go to ADV.
  - tc and jn are retained.
- ADV (1 cycle):
  - If ch == NUM_CH-1: ch=0, scan_done=1 for this cycle, cnt=0, go to HOLD.
  - Else: ch=ch+1, go to REQ.
- HOLD:
  - cnt increments.
  - When cnt == PERIOD_CYC-1: cnt=0, go to REQ.
- Encoding: illegal state codes go to REQ on the next cycle.
- ch_sel = ch in all states; it is stable throughout REQ/CAPT for a channel.
- fault_any is combinational from the fault_bits registers.
- Counters never wrap, by the CBITS constraint.
- Liveness: under G rst_n, state=REQ holds infinitely often and scan_done pulses infinitely often, independent of SPI behaviour (guaranteed by the timeout). Formal property: F G rst_n -> G F (state==REQ).
- Latency: scan period = STARTUP once, then per scan NUM_CH*(REQ+CAPT+1) + PERIOD_CYC cycles.

Test Plan:
All scenarios use CLK_FREQ=8, NUM_CH=2, STARTUP_SEC=1, PERIOD_SEC=1, TIMEOUT_CYC=5.
- Startup: release rst_n, spi_not_busy=1 → spi_ena=0 for exactly 8 cycles, then spi_ena=1 with ch_sel=0.
- Normal scan:
  - Stimulus: SPI model drops busy 2 cycles after spi_ena, returns 3 cycles later with 32'h0C80_1230 (ch0), then 32'h0640_0000 (ch1).
  - Required: tc ch0=14'h0320, jn ch0=12'h123, fault ch0=0, data_valid=2'b11.
  - Required: scan_done pulses once, then 8 HOLD cycles before the next REQ on ch0.
- Fault frame: ch1 returns 32'h0001_0001 after a good ch1 sample → fault_bits ch1=4'b1001, tc/jn ch1 unchanged, data_valid[1]=0, fault_any=1.
- Timeout: spi_not_busy held 1 and never drops on ch0 → after 5 REQ cycles fault ch0=4'b1111, ch_sel advances to 1; scan continues.
- Stuck busy: spi_not_busy stuck 0 in CAPT → timeout after 5 cycles, scan_done still pulses each scan.
- Async reset: assert rst_n=0 mid-CAPT between clock edges → all outputs 0 immediately; after release the full 8-cycle STARTUP repeats.
